control_unit: RTL and testbench

Mini-SRC hardwired control unit: a Moore state machine that sequences fetch and execute micro-steps and drives every control input of `datapath`. It sits directly upstream of `datapath`, reads back the instruction register and the branch condition flag `CON_Out`, and replaces the hand-written per-instruction `Present_state` sequencing currently carried in each testbench. One instruction completes per pass through the fetch and execute states.

---
 rtl/src_ctrl_pkg.sv | 15 +
 rtl/control_decode.sv | 38 +++
 rtl/control_unit.sv | 107 ++++++++++
 tb/tb_control_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: Mini-SRC opcodes, ALU op codes, control FSM states and instruction classes
package src_ctrl_pkg;
  localparam logic [4:0] OPC_LD = 5'b00000, OPC_LDI = 5'b00001, OPC_ST = 5'b00010;
  localparam logic [4:0] OPC_ADD = 5'b00011, OPC_SUB = 5'b00100, OPC_AND = 5'b00101, OPC_OR = 5'b00110;
  localparam logic [4:0] OPC_SHR = 5'b00111, OPC_SHRA = 5'b01000, OPC_SHL = 5'b01001;
  localparam logic [4:0] OPC_ROR = 5'b01010, OPC_ROL = 5'b01011;
  localparam logic [4:0] OPC_ADDI = 5'b01100, OPC_ANDI = 5'b01101, OPC_ORI = 5'b01110;
  localparam logic [4:0] OPC_BR = 5'b10011, OPC_JR = 5'b10100, OPC_IN = 5'b10110, OPC_OUT = 5'b10111;
  localparam logic [4:0] OPC_MFHI = 5'b11000, OPC_MFLO = 5'b11001, OPC_NOP = 5'b11010, OPC_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00100, ALU_SUB = 5'b00101, ALU_AND = 5'b00110, ALU_OR = 5'b00111;
  localparam logic [4:0] ALU_SHR = 5'b01000, ALU_SHRA = 5'b01001, ALU_SHL = 5'b01010;
  localparam logic [4:0] ALU_ROR = 5'b01011, ALU_ROL = 5'b01100;
  typedef enum logic [3:0] {S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;
  typedef enum logic [3:0] {C_NOP, C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_BR, C_JR, C_MFHI, C_MFLO, C_IN, C_OUT, C_HALT} class_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: opcode -> {instruction class, ALU op}; unsupported opcodes decode as nop
module control_decode
  import src_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output class_t     cls,
  output logic [4:0] alu_op
);
  always_comb begin
    cls = C_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OPC_LD: cls = C_LD;
      OPC_LDI: cls = C_LDI;
      OPC_ST: cls = C_ST;
      OPC_ADD: cls = C_ALU;
      OPC_SUB: begin cls = C_ALU; alu_op = ALU_SUB; end
      OPC_AND: begin cls = C_ALU; alu_op = ALU_AND; end
      OPC_OR: begin cls = C_ALU; alu_op = ALU_OR; end
      OPC_SHR: begin cls = C_ALU; alu_op = ALU_SHR; end
      OPC_SHRA: begin cls = C_ALU; alu_op = ALU_SHRA; end
      OPC_SHL: begin cls = C_ALU; alu_op = ALU_SHL; end
      OPC_ROR: begin cls = C_ALU; alu_op = ALU_ROR; end
      OPC_ROL: begin cls = C_ALU; alu_op = ALU_ROL; end
      OPC_ADDI: cls = C_IMM;
      OPC_ANDI: begin cls = C_IMM; alu_op = ALU_AND; end
      OPC_ORI: begin cls = C_IMM; alu_op = ALU_OR; end
      OPC_BR: cls = C_BR;
      OPC_JR: cls = C_JR;
      OPC_IN: cls = C_IN;
      OPC_OUT: cls = C_OUT;
      OPC_MFHI: cls = C_MFHI;
      OPC_MFLO: cls = C_MFLO;
      OPC_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: Mini-SRC Moore control FSM; Clock/Clear(async), IR/CON_Out/Stop in, datapath strobes + OP + Run out
module control_unit
  import src_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_Out,
  input  logic        Stop,
  output logic        Run,
  output logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
  output logic        PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR,
  output logic [4:0]  OP
);
  state_t state, next;
  class_t cls, cls_d;
  logic [4:0] op_q, op_d;
  logic last, unused_ir;
  assign unused_ir = ^IR[26:0];
  control_decode u_dec (.opcode(IR[31:27]), .cls(cls_d), .alu_op(op_d));
  // the class must be taken from the decoder in F2 because cls is only latched on leaving F2
  assign last = (state == S_F2 && cls_d == C_NOP)
             || (state == S_T3 && cls inside {C_JR, C_MFHI, C_MFLO, C_IN, C_OUT})
             || (state == S_T5 && cls inside {C_LDI, C_ALU, C_IMM})
             || (state == S_T6 && cls == C_BR)
             || state == S_T7;
  always_ff @(posedge Clock or posedge Clear)
    if (Clear) begin
      state <= S_RESET;
      cls <= C_NOP;
      op_q <= '0;
    end else begin
      state <= next;
      if (state == S_F2) begin
        cls <= cls_d;
        op_q <= op_d;
      end
    end
  always_comb begin
    next = state;
    case (state)
      S_RESET: next = S_F0;
      S_F0: next = S_F1;
      S_F1: next = S_F2;
      S_F2: next = cls_d == C_HALT ? S_HALT : S_T3;
      S_T3: next = S_T4;
      S_T4: next = S_T5;
      S_T5: next = S_T6;
      S_T6: next = S_T7;
      default: next = state;
    endcase
    if (last) next = Stop ? S_HALT : S_F0;
  end
  always_comb begin
    {PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin} = '0;
    {PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR} = '0;
    OP = '0;
    Run = state != S_RESET && state != S_HALT;
    case (state)
      S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_F1: begin Read = 1'b1; MDRin = 1'b1; end
      S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3:
        case (cls)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_ALU, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_BR: begin Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; end
          C_JR: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_IN: begin InPort = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
          default: ;
        endcase
      S_T4:
        case (cls)
          C_LD, C_LDI, C_ST, C_IMM: begin Cout = 1'b1; OP = op_q; ZLowin = 1'b1; end
          C_ALU: begin Grc = 1'b1; Rout = 1'b1; OP = op_q; ZLowin = 1'b1; end
          C_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      S_T5:
        case (cls)
          C_LDI, C_ALU, C_IMM: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
          C_BR: begin Cout = 1'b1; OP = op_q; ZLowin = 1'b1; end
          default: ;
        endcase
      S_T6:
        case (cls)
          C_LD: begin Read = 1'b1; MDRin = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR: begin ZLowout = CON_Out; PCin = CON_Out; end
          default: ;
        endcase
      S_T7:
        case (cls)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven check of the control_unit state sequence and strobes
module tb_control_unit;
  logic Clock = 1'b0, Clear = 1'b1, CON_Out = 1'b0, Stop = 1'b0;
  logic [31:0] IR = '0;
  logic Run;
  logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
  logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR;
  logic [4:0] OP;
  logic [34:0] obs;
  always #5 Clock = ~Clock;
  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_Out(CON_Out), .Stop(Stop), .Run(Run),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .ZLowin(ZLowin),
    .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort), .Yin(Yin),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .InPort(InPort), .MDRout(MDRout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read),
    .Write(Write), .IncPC(IncPC), .CON_In(CON_In), .GLR(GLR), .OP(OP)
  );
  assign obs = {Run, OP, GLR, CON_In, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra, Cout,
                MDRout, InPort, ZLowout, ZHighout, LOout, HIout, PCout, Yin, OutPort, MDRin, MARin,
                ZLowin, ZHighin, LOin, HIin, IRin, PCin};
  localparam logic [28:0] M_PCIN = 29'd1 << 0, M_IRIN = 29'd1 << 1, M_ZLOWIN = 29'd1 << 5,
    M_MARIN = 29'd1 << 6, M_MDRIN = 29'd1 << 7, M_OUTPORT = 29'd1 << 8, M_YIN = 29'd1 << 9,
    M_PCOUT = 29'd1 << 10, M_HIOUT = 29'd1 << 11, M_LOOUT = 29'd1 << 12, M_ZLOWOUT = 29'd1 << 14,
    M_INPORT = 29'd1 << 15, M_MDROUT = 29'd1 << 16, M_COUT = 29'd1 << 17, M_GRA = 29'd1 << 18,
    M_GRB = 29'd1 << 19, M_GRC = 29'd1 << 20, M_RIN = 29'd1 << 21, M_ROUT = 29'd1 << 22,
    M_BAOUT = 29'd1 << 23, M_READ = 29'd1 << 24, M_WRITE = 29'd1 << 25, M_INCPC = 29'd1 << 26,
    M_CONIN = 29'd1 << 27;
  localparam logic [4:0] A_ADD = 5'b00100, A_AND = 5'b00110, A_ROL = 5'b01100;
  localparam logic [31:0] I_LDI = 32'h08800075, I_LD = 32'h00800055, I_ST = 32'h10800055,
    I_ADD = 32'h18918000, I_BR = 32'h98000000, I_ROL = 32'h58000000, I_ANDI = 32'h68000000,
    I_MUL = 32'h78000000, I_NOP = 32'hD0000000, I_HALT = 32'hD8000000, I_JR = 32'hA0000000,
    I_MFHI = 32'hC0000000, I_MFLO = 32'hC8000000, I_IN = 32'hB0000000, I_OUT = 32'hB8000000;
  typedef struct {
    logic clr;
    logic [31:0] ir;
    logic con;
    logic stop;
    logic [34:0] exp;
    string tag;
  } vec_t;
  vec_t vq[$];
  int total = 0, bad = 0;
  function automatic logic [34:0] e(input logic [4:0] op, input logic [28:0] c);
    return {1'b1, op, c};
  endfunction
  task automatic chk(input string tag, input logic [34:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic clr, input logic [31:0] ir, input logic con, input logic stop,
                      input logic [34:0] exp, input string tag);
    @(negedge Clock);
    Clear = clr;
    IR = ir;
    CON_Out = con;
    Stop = stop;
    #1 chk(tag, exp);
  endtask
  task automatic add(input logic clr, input logic [31:0] ir, input logic con, input logic stop,
                     input logic [34:0] exp, input string tag);
    vec_t v;
    v.clr = clr; v.ir = ir; v.con = con; v.stop = stop; v.exp = exp; v.tag = tag;
    vq.push_back(v);
  endtask
  task automatic fetch(input logic [31:0] ir, input logic con, input string tag);
    add(0, ir, con, 0, e(0, M_PCOUT | M_MARIN | M_INCPC), {tag, "_f0"});
    add(0, ir, con, 0, e(0, M_READ | M_MDRIN), {tag, "_f1"});
    add(0, ir, con, 0, e(0, M_MDROUT | M_IRIN), {tag, "_f2"});
  endtask
  task automatic addr_calc(input logic [31:0] ir, input string tag);
    add(0, ir, 0, 0, e(0, M_GRB | M_BAOUT | M_YIN), {tag, "_t3"});
    add(0, ir, 0, 0, e(A_ADD, M_COUT | M_ZLOWIN), {tag, "_t4"});
  endtask
  task automatic single(input logic [31:0] ir, input logic [28:0] c, input string tag);
    fetch(ir, 0, tag);
    add(0, ir, 0, 0, e(0, c), {tag, "_t3"});
  endtask
  task automatic branch(input logic con, input string tag);
    fetch(I_BR, con, tag);
    add(0, I_BR, con, 0, e(0, M_GRA | M_ROUT | M_CONIN), {tag, "_t3"});
    add(0, I_BR, con, 0, e(0, M_PCOUT | M_YIN), {tag, "_t4"});
    add(0, I_BR, con, 0, e(A_ADD, M_COUT | M_ZLOWIN), {tag, "_t5"});
    add(0, I_BR, con, 0, e(0, con ? (M_ZLOWOUT | M_PCIN) : 29'd0), {tag, "_t6"});
  endtask
  initial begin
    add(1, I_LDI, 0, 0, '0, "reset");
    add(0, I_LDI, 0, 0, '0, "reset_release");
    fetch(I_LDI, 0, "ldi");
    addr_calc(I_LDI, "ldi");
    add(0, I_LDI, 0, 0, e(0, M_ZLOWOUT | M_GRA | M_RIN), "ldi_t5");
    fetch(I_LD, 0, "ld");
    addr_calc(I_LD, "ld");
    add(0, I_LD, 0, 0, e(0, M_ZLOWOUT | M_MARIN), "ld_t5");
    add(0, I_LD, 0, 0, e(0, M_READ | M_MDRIN), "ld_t6");
    add(0, I_LD, 0, 0, e(0, M_MDROUT | M_GRA | M_RIN), "ld_t7");
    fetch(I_ST, 0, "st");
    addr_calc(I_ST, "st");
    add(0, I_ST, 0, 0, e(0, M_ZLOWOUT | M_MARIN), "st_t5");
    add(0, I_ST, 0, 0, e(0, M_GRA | M_ROUT | M_MDRIN), "st_t6");
    add(0, I_ST, 0, 0, e(0, M_WRITE), "st_t7");
    branch(0, "br_nt");
    branch(1, "br_tk");
    fetch(I_ADD, 0, "add");
    add(0, I_ADD, 0, 0, e(0, M_GRB | M_ROUT | M_YIN), "add_t3");
    add(0, I_ADD, 0, 0, e(A_ADD, M_GRC | M_ROUT | M_ZLOWIN), "add_t4");
    add(0, I_ADD, 0, 0, e(0, M_ZLOWOUT | M_GRA | M_RIN), "add_t5");
    fetch(I_ROL, 0, "rol");
    add(0, I_ROL, 0, 0, e(0, M_GRB | M_ROUT | M_YIN), "rol_t3");
    add(0, I_ROL, 0, 0, e(A_ROL, M_GRC | M_ROUT | M_ZLOWIN), "rol_t4");
    add(0, I_ROL, 0, 0, e(0, M_ZLOWOUT | M_GRA | M_RIN), "rol_t5");
    fetch(I_ANDI, 0, "andi");
    add(0, I_ANDI, 0, 0, e(0, M_GRB | M_ROUT | M_YIN), "andi_t3");
    add(0, I_ANDI, 0, 0, e(A_AND, M_COUT | M_ZLOWIN), "andi_t4");
    add(0, I_ANDI, 0, 0, e(0, M_ZLOWOUT | M_GRA | M_RIN), "andi_t5");
    fetch(I_MUL, 0, "mul");
    fetch(I_NOP, 0, "nop");
    single(I_JR, M_GRA | M_ROUT | M_PCIN, "jr");
    single(I_MFHI, M_HIOUT | M_GRA | M_RIN, "mfhi");
    single(I_MFLO, M_LOOUT | M_GRA | M_RIN, "mflo");
    single(I_IN, M_INPORT | M_GRA | M_RIN, "in");
    single(I_OUT, M_GRA | M_ROUT | M_OUTPORT, "out");
    fetch(I_ADD, 0, "stop");
    add(0, I_ADD, 0, 0, e(0, M_GRB | M_ROUT | M_YIN), "stop_t3");
    add(0, I_ADD, 0, 1, e(A_ADD, M_GRC | M_ROUT | M_ZLOWIN), "stop_t4");
    add(0, I_ADD, 0, 1, e(0, M_ZLOWOUT | M_GRA | M_RIN), "stop_t5");
    for (int i = 0; i < 3; i++) add(0, I_ADD, 0, 0, '0, "stop_halted");
    add(1, I_HALT, 0, 0, '0, "halt_clr");
    add(0, I_HALT, 0, 0, '0, "halt_rel");
    fetch(I_HALT, 0, "halt");
    for (int i = 0; i < 20; i++) add(0, I_HALT, 0, 0, '0, "halt_hold");
    add(1, I_ADD, 0, 0, '0, "resume_clr");
    add(0, I_ADD, 0, 0, '0, "resume_rel");
    fetch(I_ADD, 0, "resume");
    add(0, I_ADD, 0, 0, e(0, M_GRB | M_ROUT | M_YIN), "resume_t3");
    add(0, I_ADD, 0, 0, e(A_ADD, M_GRC | M_ROUT | M_ZLOWIN), "resume_t4");
    foreach (vq[i]) step(vq[i].clr, vq[i].ir, vq[i].con, vq[i].stop, vq[i].exp, vq[i].tag);
    #2 Clear = 1'b1;
    #1 chk("async_clear", '0);
    step(0, I_ADD, 0, 0, '0, "async_rel");
    step(0, I_ADD, 0, 0, e(0, M_PCOUT | M_MARIN | M_INCPC), "async_f0");
    step(0, I_ADD, 0, 0, e(0, M_READ | M_MDRIN), "async_f1");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
